// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes, FSM states
// and the default iteration count.
package mdu_iter_pkg;

    localparam int MDU_DATA_WIDTH = 32;
    localparam int MDU_ITER       = MDU_DATA_WIDTH;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MUL1 = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/div_radix2_core.sv
// One combinational restoring-divide step on unsigned magnitudes:
// shift the next dividend bit into the remainder, subtract the divisor if it fits.
module div_radix2_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic [DATA_WIDTH-1:0] quo_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic [DATA_WIDTH-1:0] quo_out
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                fits;

    // The remainder stays below the divisor, so the difference always fits DATA_WIDTH bits.
    always_comb begin
        shifted = {rem_in, quo_in[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        fits    = (shifted >= {1'b0, divisor});
        rem_out = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        quo_out = {quo_in[DATA_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with pipeline stall output.
// Optional MDU_FAST_MULT_EN: multiplies use a two-cycle array multiplier instead of the iterative path.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  EXE_MDU_Start,
    input  mdu_op_t               EXE_MDU_Op,
    input  logic [DATA_WIDTH-1:0] EXE_rs,
    input  logic [DATA_WIDTH-1:0] EXE_rt,
    input  logic                  EXE_Wr,
    input  logic                  Flush_Exception,
    output logic                  DIVMULTBusy,
    output logic                  MDU_ResValid,
    output logic [DATA_WIDTH-1:0] MDU_Hi,
    output logic [DATA_WIDTH-1:0] MDU_Lo
);

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST_MULT = 1'b1;
`else
    localparam bit FAST_MULT = 1'b0;
`endif

    mdu_state_t            state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  accept;
    logic [DATA_WIDTH-1:0] hi_r, lo_r, opnd_r;
    logic                  neg_a_r, neg_b_r, is_div_r, div_zero_r;

    logic                  op_is_div, op_is_signed, neg_a, neg_b;
    logic signed [DATA_WIDTH-1:0] rs_s, rt_s;
    logic [DATA_WIDTH-1:0] mag_a, mag_b;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;
    logic [2*DATA_WIDTH-1:0] res_fix;

    // Signs are restored from the latched flags; a zero divisor bypasses the quotient fix-up.
    function automatic logic [2*DATA_WIDTH-1:0] fix_up(
        input logic                  is_div,
        input logic                  na,
        input logic                  nb,
        input logic                  dz,
        input logic [DATA_WIDTH-1:0] hi,
        input logic [DATA_WIDTH-1:0] lo
    );
        logic [DATA_WIDTH-1:0]   q;
        logic [DATA_WIDTH-1:0]   r;
        logic [2*DATA_WIDTH-1:0] p;
        q = (na ^ nb) ? -lo : lo;
        if (dz)
            q = '1;
        r = na ? -hi : hi;
        p = {hi, lo};
        if (na ^ nb)
            p = -p;
        return is_div ? {r, q} : p;
    endfunction

    always_comb begin
        op_is_div    = (EXE_MDU_Op == MDU_DIV) || (EXE_MDU_Op == MDU_DIVU);
        op_is_signed = (EXE_MDU_Op == MDU_DIV) || (EXE_MDU_Op == MDU_MULT);
        rs_s         = EXE_rs;
        rt_s         = EXE_rt;
        neg_a        = op_is_signed && (rs_s < 0);
        neg_b        = op_is_signed && (rt_s < 0);
        mag_a        = neg_a ? -EXE_rs : EXE_rs;
        mag_b        = neg_b ? -EXE_rt : EXE_rt;
        mul_sum      = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);
    end

    div_radix2_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_step (
        .rem_in  (hi_r),
        .quo_in  (lo_r),
        .divisor (opnd_r),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        DIVMULTBusy  = 1'b0;
        MDU_ResValid = 1'b0;
        case (state)
            IDLE: begin
                if (EXE_MDU_Start && !Flush_Exception) begin
                    accept      = 1'b1;
                    DIVMULTBusy = 1'b1;
                    state_nxt   = (FAST_MULT && !op_is_div) ? MUL1 : RUN;
                end
            end
            RUN: begin
                DIVMULTBusy = 1'b1;
                if (cnt == CNT_WIDTH'(DATA_WIDTH - 1))
                    state_nxt = DONE;
            end
            MUL1: begin
                DIVMULTBusy = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                MDU_ResValid = 1'b1;
                if (EXE_Wr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (Flush_Exception) begin
            state_nxt    = IDLE;
            DIVMULTBusy  = 1'b0;
            MDU_ResValid = 1'b0;
        end
    end

    // Multiply keeps {hi_r, lo_r} as the shifting product; divide keeps remainder/quotient there.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            opnd_r     <= '0;
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            is_div_r   <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            hi_r       <= '0;
            lo_r       <= op_is_div ? mag_a : mag_b;
            opnd_r     <= op_is_div ? mag_b : mag_a;
            neg_a_r    <= neg_a;
            neg_b_r    <= neg_b;
            is_div_r   <= op_is_div;
            div_zero_r <= op_is_div && (EXE_rt == '0);
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (is_div_r) begin
                hi_r <= rem_nxt;
                lo_r <= quo_nxt;
            end else begin
                hi_r <= mul_sum[DATA_WIDTH:1];
                lo_r <= {mul_sum[0], lo_r[DATA_WIDTH-1:1]};
            end
        end
`ifdef MDU_FAST_MULT_EN
        else if (state == MUL1) begin
            {hi_r, lo_r} <= {{DATA_WIDTH{1'b0}}, opnd_r} * {{DATA_WIDTH{1'b0}}, lo_r};
        end
`endif
    end

    always_comb begin
        res_fix = fix_up(is_div_r, neg_a_r, neg_b_r, div_zero_r, hi_r, lo_r);
        {MDU_Hi, MDU_Lo} = MDU_ResValid ? res_fix : '0;
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter against a plain-arithmetic reference model.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        EXE_MDU_Start;
    mdu_op_t     EXE_MDU_Op;
    logic [31:0] EXE_rs, EXE_rt;
    logic        EXE_Wr;
    logic        Flush_Exception;
    logic        DIVMULTBusy, MDU_ResValid;
    logic [31:0] MDU_Hi, MDU_Lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mdu_iter dut (
        .clk             (clk),
        .resetn          (resetn),
        .EXE_MDU_Start   (EXE_MDU_Start),
        .EXE_MDU_Op      (EXE_MDU_Op),
        .EXE_rs          (EXE_rs),
        .EXE_rt          (EXE_rt),
        .EXE_Wr          (EXE_Wr),
        .Flush_Exception (Flush_Exception),
        .DIVMULTBusy     (DIVMULTBusy),
        .MDU_ResValid    (MDU_ResValid),
        .MDU_Hi          (MDU_Hi),
        .MDU_Lo          (MDU_Lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {HI, LO} from the architectural definition of each operation.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            2'd0: begin p = sa * sb; return p; end
            2'd1: begin p = ua * ub; return p; end
            2'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = ua / ub; r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op);
`ifdef MDU_FAST_MULT_EN
        if (op == 2'd0 || op == 2'd1) return 2;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        bit          busy_ok;
        logic [63:0] exp;
        exp           = ref_model(op, a, b);
        EXE_MDU_Start = 1'b1;
        EXE_MDU_Op    = mdu_op_t'(op);
        EXE_rs        = a;
        EXE_rt        = b;
        EXE_Wr        = 1'b0;
        #1;
        chk({tag, "_accept"}, {DIVMULTBusy, MDU_ResValid}, 2'b10);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (MDU_ResValid) break;
            if (!DIVMULTBusy) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, lat, exp_latency(op));
        chk({tag, "_busy_run"}, busy_ok, 1'b1);
        chk({tag, "_result"}, {MDU_Hi, MDU_Lo}, exp);
        chk({tag, "_busy_done"}, DIVMULTBusy, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {MDU_ResValid, DIVMULTBusy, MDU_Hi, MDU_Lo}, {2'b10, exp});
        end
        EXE_Wr = 1'b1;
        @(negedge clk);
        EXE_Wr = 1'b0;
        EXE_MDU_Start = 1'b0;
        #1;
        chk({tag, "_idle"}, {MDU_ResValid, DIVMULTBusy}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        resetn          = 1'b0;
        EXE_MDU_Start   = 1'b0;
        EXE_MDU_Op      = MDU_MULT;
        EXE_rs          = '0;
        EXE_rt          = '0;
        EXE_Wr          = 1'b0;
        Flush_Exception = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {DIVMULTBusy, MDU_ResValid, MDU_Hi, MDU_Lo}, 66'h0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 0);
        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mult_m1_2", 2'd0, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("multu_m1_2", 2'd1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("divu_5_0", 2'd3, 32'd5, 32'd0, 0);
        run_op("div_m5_0", 2'd2, 32'hFFFF_FFFB, 32'd0, 0);
        run_op("hold4", 2'd3, 32'd1000, 32'd9, 4);
        run_op("b2b_divu", 2'd3, 32'hDEAD_BEEF, 32'd1234, 0);
        run_op("b2b_multu", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        // Flush ten cycles into a divide.
        EXE_MDU_Start = 1'b1;
        EXE_MDU_Op    = MDU_DIVU;
        EXE_rs        = 32'd1000;
        EXE_rt        = 32'd3;
        repeat (10) @(negedge clk);
        Flush_Exception = 1'b1;
        #1;
        chk("flush_same_cycle", {DIVMULTBusy, MDU_ResValid}, 2'b00);
        @(negedge clk);
        Flush_Exception = 1'b0;
        EXE_MDU_Start   = 1'b0;
        #1;
        chk("flush_idle", {DIVMULTBusy, MDU_ResValid, MDU_Hi, MDU_Lo}, 66'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (MDU_ResValid || DIVMULTBusy) seen = 1'b1;
        end
        chk("flush_no_result", seen, 1'b0);

        // Reset twenty cycles into a divide.
        EXE_MDU_Start = 1'b1;
        EXE_MDU_Op    = MDU_DIV;
        EXE_rs        = 32'h7654_3210;
        EXE_rt        = 32'hFFFF_FF00;
        repeat (20) @(negedge clk);
        resetn        = 1'b0;
        EXE_MDU_Start = 1'b0;
        @(negedge clk);
        chk("reset_mid_op", {DIVMULTBusy, MDU_ResValid, MDU_Hi, MDU_Lo}, 66'h0);
        resetn = 1'b1;
        @(negedge clk);
        run_op("after_reset", 2'd0, 32'hFFFF_FFF9, 32'h0000_0003, 0);

        for (int n = 0; n < 30; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            run_op("random", op, a, b, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
